// File: rtl/line_cmd_sched.sv
// Line-command scheduler: queues complete line commands in a small FIFO and
// replays each onto the Bresenham engine's point bus, tracking it to completion.
module line_cmd_sched #(
  parameter int DEPTH    = 4,
  parameter int PTR_W    = 2,
  parameter int START_TO = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [9:0]       cmd_x0,
  input  logic [9:0]       cmd_y0,
  input  logic [9:0]       cmd_x1,
  input  logic [9:0]       cmd_y1,
  input  logic [31:0]      cmd_color,
  input  logic             flush,
  output logic [PTR_W:0]   cmd_count,
  output logic             busy,
  output logic [15:0]      lines_done,
  output logic [7:0]       retries,
  input  logic             LE_ready,
  output logic [9:0]       LE_point,
  output logic [31:0]      LE_color,
  output logic             LE_x0_valid,
  output logic             LE_y0_valid,
  output logic             LE_x1_valid,
  output logic             LE_y1_valid,
  output logic             LE_color_valid,
  output logic             LE_trigger
);

  typedef struct packed {
    logic [9:0]  x0;
    logic [9:0]  y0;
    logic [9:0]  x1;
    logic [9:0]  y1;
    logic [31:0] color;
  } cmd_t;

  typedef enum logic [3:0] {
    S_IDLE, S_LD_X0, S_LD_Y0, S_LD_X1, S_LD_Y1, S_LD_COL,
    S_TRIG, S_WAIT_START, S_WAIT_DONE
  } state_t;

  localparam int             TO_W     = $clog2(START_TO + 1);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TO - 1);

  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  cmd_t             work_q;
  cmd_t             cmd_in;
  state_t           state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q;
  logic [15:0]      lines_q;
  logic [7:0]       retries_q;
  logic             push, pop, to_expired;

  assign cmd_in     = {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color};
  assign cmd_ready  = (count_q != FULL_CNT) && !rst && !flush;
  assign push       = cmd_valid && cmd_ready;
  // Start a line only when the engine is idle; flush wins over the pop.
  assign pop        = (state_q == S_IDLE) && (count_q != '0) && LE_ready && !flush;
  assign to_expired = (to_cnt_q == TO_LAST);

  assign cmd_count  = count_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign lines_done = lines_q;
  assign retries    = retries_q;

  // NOTE: the storage array has no reset; occupancy is tracked solely by the
  // pointers and count, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)      work_q <= '0;
    else if (pop) work_q <= mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (pop) state_d = S_LD_X0;
      S_LD_X0:      state_d = S_LD_Y0;
      S_LD_Y0:      state_d = S_LD_X1;
      S_LD_X1:      state_d = S_LD_Y1;
      S_LD_Y1:      state_d = S_LD_COL;
      S_LD_COL:     state_d = S_TRIG;
      S_TRIG:       state_d = S_WAIT_START;
      S_WAIT_START: begin
        if (!LE_ready)       state_d = S_WAIT_DONE;
        else if (to_expired) state_d = S_TRIG;
      end
      S_WAIT_DONE:  if (LE_ready) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Start timeout restarts on every trigger; retries saturate, lines_done wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      retries_q <= '0;
      lines_q   <= '0;
    end else begin
      if (state_q == S_TRIG)
        to_cnt_q <= '0;
      else if (state_q == S_WAIT_START && LE_ready && !to_expired)
        to_cnt_q <= to_cnt_q + 1'b1;
      if (state_q == S_WAIT_START && LE_ready && to_expired && retries_q != 8'hFF)
        retries_q <= retries_q + 1'b1;
      if (state_q == S_WAIT_DONE && LE_ready)
        lines_q <= lines_q + 1'b1;
    end
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    LE_point       = '0;
    LE_x0_valid    = 1'b0;
    LE_y0_valid    = 1'b0;
    LE_x1_valid    = 1'b0;
    LE_y1_valid    = 1'b0;
    LE_color_valid = 1'b0;
    LE_trigger     = 1'b0;
    LE_color       = (state_q == S_IDLE) ? '0 : work_q.color;
    case (state_q)
      S_LD_X0:  begin LE_x0_valid = 1'b1; LE_point = work_q.x0; end
      S_LD_Y0:  begin LE_y0_valid = 1'b1; LE_point = work_q.y0; end
      S_LD_X1:  begin LE_x1_valid = 1'b1; LE_point = work_q.x1; end
      S_LD_Y1:  begin LE_y1_valid = 1'b1; LE_point = work_q.y1; end
      S_LD_COL: LE_color_valid = 1'b1;
      S_TRIG:   LE_trigger     = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_line_cmd_sched.sv
// Self-checking bench for line_cmd_sched: engine model drives LE_ready, a
// monitor logs bus events, and a command-queue model predicts the event stream.
module tb_line_cmd_sched;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [9:0]  x0;
    logic [9:0]  y0;
    logic [9:0]  x1;
    logic [9:0]  y1;
    logic [31:0] color;
  } cmd_t;

  // kind: 0..3 = x0,y0,x1,y1 strobe, 4 = color strobe, 5 = trigger
  typedef struct {
    int          kind;
    logic [31:0] val;
    int          cyc;
  } ev_t;

  logic        clk, rst, cmd_valid, cmd_ready, flush, busy, LE_ready;
  logic [9:0]  cmd_x0, cmd_y0, cmd_x1, cmd_y1, LE_point;
  logic [31:0] cmd_color, LE_color;
  logic [2:0]  cmd_count;
  logic [15:0] lines_done;
  logic [7:0]  retries;
  logic        LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid;
  logic        LE_color_valid, LE_trigger;

  line_cmd_sched #(.DEPTH(DEPTH), .PTR_W(2), .START_TO(3)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .flush(flush), .cmd_count(cmd_count), .busy(busy),
    .lines_done(lines_done), .retries(retries), .LE_ready(LE_ready),
    .LE_point(LE_point), .LE_color(LE_color), .LE_x0_valid(LE_x0_valid),
    .LE_y0_valid(LE_y0_valid), .LE_x1_valid(LE_x1_valid),
    .LE_y1_valid(LE_y1_valid), .LE_color_valid(LE_color_valid),
    .LE_trigger(LE_trigger)
  );

  int   n_cmp = 0, n_err = 0;
  int   cyc = 0;
  int   push_edge = 0;
  int   multi_hot = 0, point_leak = 0;
  ev_t  obs_q[$];
  ev_t  exp_q[$];
  int   obs_rd = 0;
  cmd_t mq[$];

  // Engine model controls (written only by the stimulus block)
  bit   eng_hold = 0;
  int   eng_busy_len = 40;
  int   eng_ignore_req = 0;
  // Engine model state (written only by the engine process)
  int   eng_cnt = 0;
  bit   eng_pending = 0;
  int   eng_ignored = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign LE_ready = !eng_hold && (eng_cnt == 0);

  // Engine: drops ready one cycle after an accepted trigger, busy for eng_busy_len cycles.
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      eng_cnt     = 0;
      eng_pending = 0;
    end else begin
      if (eng_cnt > 0) eng_cnt--;
      if (eng_pending) begin
        eng_pending = 0;
        eng_cnt     = eng_busy_len;
      end
      if (LE_trigger) begin
        if (eng_ignored < eng_ignore_req) eng_ignored++;
        else eng_pending = 1;
      end
    end
  end

  always @(negedge clk) begin : monitor
    int n;
    n = int'(LE_x0_valid) + int'(LE_y0_valid) + int'(LE_x1_valid) +
        int'(LE_y1_valid) + int'(LE_color_valid) + int'(LE_trigger);
    if (!rst) begin
      if (n > 1) multi_hot++;
      if (!(LE_x0_valid || LE_y0_valid || LE_x1_valid || LE_y1_valid) && LE_point != '0)
        point_leak++;
      if (LE_x0_valid)    obs_q.push_back('{0, 32'(LE_point), cyc});
      if (LE_y0_valid)    obs_q.push_back('{1, 32'(LE_point), cyc});
      if (LE_x1_valid)    obs_q.push_back('{2, 32'(LE_point), cyc});
      if (LE_y1_valid)    obs_q.push_back('{3, 32'(LE_point), cyc});
      if (LE_color_valid) obs_q.push_back('{4, LE_color, cyc});
      if (LE_trigger)     obs_q.push_back('{5, 32'd0, cyc});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.x0    = 10'($urandom_range(0, 1023));
    c.y0    = 10'($urandom_range(0, 1023));
    c.x1    = 10'($urandom_range(0, 1023));
    c.y1    = 10'($urandom_range(0, 1023));
    c.color = $urandom() & 32'h00FF_FFFF;
    return c;
  endfunction

  // Reference model: FIFO of accepted commands; each started line emits
  // four coordinate loads, one color load and ntrig triggers, in that order.
  task automatic model_start(input int ntrig);
    cmd_t c;
    c = mq.pop_front();
    exp_q.push_back('{0, 32'(c.x0), 0});
    exp_q.push_back('{1, 32'(c.y0), 0});
    exp_q.push_back('{2, 32'(c.x1), 0});
    exp_q.push_back('{3, 32'(c.y1), 0});
    exp_q.push_back('{4, c.color, 0});
    for (int i = 0; i < ntrig; i++) exp_q.push_back('{5, 32'd0, 0});
  endtask

  task automatic model_drain();
    while (mq.size() > 0) model_start(1);
  endtask

  task automatic push(input string tag, input cmd_t c);
    bit exp_acc;
    exp_acc   = (mq.size() < DEPTH);
    cmd_valid = 1'b1;
    cmd_x0    = c.x0;
    cmd_y0    = c.y0;
    cmd_x1    = c.x1;
    cmd_y1    = c.y1;
    cmd_color = c.color;
    check({tag, "_ready"}, cmd_ready, exp_acc);
    step();
    cmd_valid = 1'b0;
    push_edge = cyc;
    if (exp_acc) mq.push_back(c);
  endtask

  task automatic wait_lines(input string tag, input int target);
    int n = 0;
    while (lines_done !== 16'(target) && n < 2000) begin
      sample();
      n++;
    end
    check(tag, lines_done, target);
  endtask

  task automatic compare_events(input string tag);
    int nobs, n;
    nobs = obs_q.size() - obs_rd;
    check({tag, "_nev"}, nobs, exp_q.size());
    n = (nobs < exp_q.size()) ? nobs : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_kind%0d", tag, i), obs_q[obs_rd + i].kind, exp_q[i].kind);
      check($sformatf("%s_val%0d", tag, i), obs_q[obs_rd + i].val, exp_q[i].val);
    end
    obs_rd = obs_q.size();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, cmd_ready, 0);
    check({tag, "_count"}, cmd_count, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_lines"}, lines_done, 0);
    check({tag, "_retries"}, retries, 0);
    check({tag, "_point"}, LE_point, 0);
    check({tag, "_color"}, LE_color, 0);
    check({tag, "_strobes"}, {LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid,
                              LE_color_valid, LE_trigger}, 0);
  endtask

  initial begin
    cmd_t c, ca, cb;
    rst = 1'b1; cmd_valid = 1'b0; flush = 1'b0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_color = '0;

    // Reset state
    step(); step();
    sample();
    check_reset_outputs("rst");
    step();
    rst = 1'b0;
    sample();
    check("post_rst_ready", cmd_ready, 1);

    // Single line with fixed coordinates and latency
    c = '{x0: 10'd10, y0: 10'd20, x1: 10'd50, y1: 10'd30, color: 32'h00FF_0000};
    push("s1_push", c);
    model_drain();
    wait_lines("s1_lines", 1);
    check("s1_busy", busy, 0);
    if (obs_q.size() - obs_rd >= 6) begin
      check("s1_x0_lat", obs_q[obs_rd].cyc - push_edge, 1);
      check("s1_trig_lat", obs_q[obs_rd + 5].cyc - push_edge, 6);
    end
    compare_events("s1");

    // Fill with engine held busy: fifth push refused
    eng_hold = 1'b1;
    for (int i = 0; i < 5; i++) push($sformatf("fill%0d", i), rand_cmd());
    sample();
    check("fill_count", cmd_count, 4);
    check("fill_ready_low", cmd_ready, 0);
    check("fill_busy", busy, 1);
    step();
    eng_hold = 1'b0;
    model_drain();
    wait_lines("fill_lines", 5);
    compare_events("fill");

    // Simultaneous push and pop at count 1
    eng_hold = 1'b1;
    ca = rand_cmd();
    cb = rand_cmd();
    push("sp_a", ca);
    eng_hold = 1'b0;
    push("sp_b", cb);
    sample();
    check("sp_count", cmd_count, 1);
    check("sp_x0_strobe", LE_x0_valid, 1);
    check("sp_x0_point", LE_point, ca.x0);
    model_drain();
    wait_lines("sp_lines", 7);
    compare_events("sp");

    // Flush during LD_Y0 of the first of three queued lines
    ca = rand_cmd();
    push("fl_0", ca);
    push("fl_1", rand_cmd());
    push("fl_2", rand_cmd());
    flush = 1'b1;
    sample();
    check("fl_in_y0", LE_y0_valid, 1);
    check("fl_y0_point", LE_point, ca.y0);
    check("fl_ready_low", cmd_ready, 0);
    step();
    flush = 1'b0;
    sample();
    check("fl_count", cmd_count, 0);
    model_start(1);
    mq.delete();
    wait_lines("fl_lines", 8);
    for (int i = 0; i < 10; i++) step();
    sample();
    check("fl_lines_stable", lines_done, 8);
    check("fl_idle", busy, 0);
    compare_events("fl");

    // Retry: engine ignores the first trigger
    eng_ignore_req = eng_ignored + 1;
    push("rt_push", rand_cmd());
    model_start(2);
    wait_lines("rt_lines", 9);
    check("rt_retries", retries, 1);
    if (obs_q.size() - obs_rd >= 7) begin
      check("rt_trig1_lat", obs_q[obs_rd + 5].cyc - push_edge, 6);
      check("rt_retrig_gap", obs_q[obs_rd + 6].cyc - obs_q[obs_rd + 5].cyc, 4);
    end
    compare_events("rt");

    // Reset during WAIT_DONE with two commands queued
    push("rs_0", rand_cmd());
    push("rs_1", rand_cmd());
    push("rs_2", rand_cmd());
    for (int i = 0; i < 7; i++) step();
    sample();
    check("rs_pre_busy", busy, 1);
    check("rs_pre_count", cmd_count, 2);
    step();
    rst = 1'b1;
    step();
    sample();
    check_reset_outputs("rs");
    model_start(1);
    mq.delete();
    compare_events("rs");
    step();
    rst = 1'b0;
    sample();
    check("rs_release_ready", cmd_ready, 1);

    // Randomized tail: random engine busy time and idle gaps
    for (int i = 0; i < 3; i++) begin
      int gap;
      eng_busy_len = $urandom_range(1, 20);
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) step();
      push($sformatf("rnd%0d", i), rand_cmd());
      model_start(1);
      wait_lines($sformatf("rnd%0d_lines", i), i + 1);
    end
    compare_events("rnd");

    check("onehot_strobes", multi_hot, 0);
    check("idle_point_zero", point_leak, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/line_cmd_sched.md
# line_cmd_sched

Line-command scheduler in front of the Bresenham line engine. Buffers complete line commands (x0, y0, x1, y1, color) from the CPU/MMIO side in a small FIFO. Replays each command onto the engine's shared point bus as a fixed sequence of single-cycle valid strobes, then issues a one-cycle trigger. Tracks each line to completion through the engine's ready handshake, so software can post several lines back-to-back without polling the engine.

## Interface
Parameters:
- DEPTH, 4: command FIFO entries; power of two, ≥2.
- PTR_W, 2: log2(DEPTH).
- START_TO, 3: cycles to wait for LE_ready to fall after a trigger before re-triggering.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present on cmd_* this cycle.
- cmd_ready  out  1  FIFO can accept; equals !full && !rst && !flush.
- cmd_x0, cmd_y0, cmd_x1, cmd_y1  in  10 each  endpoint coordinates.
- cmd_color  in  32  {8'h00, R, G, B}.
- flush  in  1  discard all queued, not-yet-started commands.
- cmd_count  out  PTR_W+1  FIFO occupancy.
- busy  out  1  FSM not in IDLE, or cmd_count != 0.
- lines_done  out  16  completed-line counter, wraps at 16'hFFFF→0.
- retries  out  8  re-trigger counter, saturates at 8'hFF.
- LE_ready  in  1  engine idle.
- LE_point  out  10  shared coordinate bus.
- LE_color  out  32  color bus.
- LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_color_valid  out  1 each  load strobes.
- LE_trigger  out  1  start-draw strobe.

## Operation
- FIFO: push on cmd_valid && cmd_ready. Pop only in IDLE when the engine start condition holds. A simultaneous push and pop leaves cmd_count unchanged. Pointers wrap modulo DEPTH.
- flush: clears pointers and count on the next edge. It does not affect the command already popped into the working register. Flush has priority over any pop in the same cycle.
- FSM states: IDLE, LD_X0, LD_Y0, LD_X1, LD_Y1, LD_COL, TRIG, WAIT_START, WAIT_DONE.
- IDLE → LD_X0 when cmd_count != 0 && LE_ready && !flush. On the same edge, the FIFO head is popped into the working register.
- LD_X0 → LD_Y0 → LD_X1 → LD_Y1 → LD_COL → TRIG advance unconditionally, one cycle each.
- TRIG → WAIT_START.
- WAIT_START:
  - → WAIT_DONE when LE_ready == 0.
  - Otherwise, after START_TO consecutive cycles with LE_ready high → TRIG again, and retries increments.
- WAIT_DONE → IDLE when LE_ready == 1. lines_done increments on this transition.
- Outputs are a Moore decode of the state:
  - LD_X0, LD_Y0, LD_X1, LD_Y1: exactly one of the four coordinate strobes is high, and LE_point carries the matching working-register field.
  - LD_COL: LE_color_valid is high.
  - LE_color is driven from the working register in every non-IDLE state.
  - All other states: LE_point = 0, all strobes = 0.
  - LE_trigger is high only in TRIG.
- At most one strobe or trigger is high in any cycle.

## Timing
- Reset values:
  - state IDLE, FIFO empty, cmd_count 0, cmd_ready 0 while rst is high.
  - LE_point 0, LE_color 0, all strobes 0.
  - busy 0, lines_done 0, retries 0.
- Reset mid-sequence drops all strobes on the next cycle. It does not wait for the engine.
- Latency: a push at edge E into an empty FIFO, with the engine idle:
  - LE_x0_valid is high in the cycle after E+1.
  - LE_trigger is high 5 cycles later, i.e. trigger in the cycle after E+6.
- Back-to-back lines: the next LD_X0 starts no earlier than the cycle after WAIT_DONE sees LE_ready == 1.
- While cmd_count == DEPTH, cmd_ready is 0 and pushes are ignored.
- A FIFO slot frees on the pop edge, not at line completion.
- Working register, lines_done and retries change only on clk edges.

## Test plan
- Single line: push (10,20,50,30,0x00FF0000); the engine model drops LE_ready 1 cycle after trigger and holds it low 40 cycles.
  - Required: strobe order x0,y0,x1,y1,color with LE_point 10,20,50,30.
  - Required: trigger 6 cycles after the push edge, then lines_done = 1 and busy = 0.
- Fill: push 5 commands back-to-back with DEPTH = 4 while LE_ready is held low.
  - Required: cmd_ready drops after 4 pushes, the 5th push is not accepted, cmd_count = 4.
  - Then release LE_ready: 4 lines are sequenced in order and lines_done = 4.
- Simultaneous push/pop: push on the exact edge the FSM pops, with cmd_count = 1.
  - Required: cmd_count stays 1 and the second command executes next.
- Flush: queue 3 commands, assert flush during LD_Y0 of the first.
  - Required: the first line completes, cmd_count = 0, the FSM returns to IDLE, lines_done = 1.
- Retry: the engine model ignores the first trigger (LE_ready stays high).
  - Required: after 3 cycles the FSM returns to TRIG, retries = 1, the second trigger is accepted, and the line completes.
- Reset during WAIT_DONE with 2 commands queued.
  - Required: the next cycle shows all outputs at reset values, cmd_count 0, lines_done 0.
